// File: rtl/edge_counter_pkg.sv
// rtl/edge_counter_pkg.sv - shared edge-mode encodings and sizing helper for the edge counter bank
//
// Purpose: common definitions imported by edge_counter_chan and edge_counter_bank.
//   edge_mode_e : encodings for the EDGE_MODE parameter (rise / fall / both).
//   sel_width() : readout select width, max(1, clog2(nchan)).
package edge_counter_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // A single channel still needs a 1-bit select port.
  function automatic int sel_width(input int nchan);
    return (nchan <= 2) ? 1 : $clog2(nchan);
  endfunction

endpackage

// File: rtl/edge_counter_chan.sv
// rtl/edge_counter_chan.sv - one edge-detecting event counter with threshold and overflow flags
//
// Purpose: detects the configured edge on evt and counts it, wrapping or saturating
// at all-ones, with sticky hit (count reached thresh) and ovf flags.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   evt        : raw event level, synchronous to clk
//   en         : count enable (edge detector history tracks evt regardless)
//   clr        : synchronous clear of cnt/hit/ovf, wins over a same-cycle edge
//   thresh     : threshold compared against the post-increment count
//   cnt        : current count
//   hit, ovf   : sticky threshold and overflow flags
module edge_counter_chan
  import edge_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = 0,
  parameter int SATURATE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] cnt,
  output logic             hit,
  output logic             ovf
);

  logic             prev_q, prev_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             ovf_q, ovf_d;

  logic             edge_det;
  logic             at_max;
  logic [WIDTH-1:0] inc_val;

  always_comb begin
    edge_det = evt & ~prev_q;
    if (EDGE_MODE == int'(EDGE_FALL)) begin
      edge_det = ~evt & prev_q;
    end else if (EDGE_MODE == int'(EDGE_BOTH)) begin
      edge_det = evt ^ prev_q;
    end
  end

  assign at_max  = (cnt_q == {WIDTH{1'b1}});
  // Natural WIDTH-bit wrap: all-ones + 1 gives 0.
  assign inc_val = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    prev_d = evt;
    cnt_d  = cnt_q;
    hit_d  = hit_q;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = '0;
      hit_d = 1'b0;
      ovf_d = 1'b0;
    end else if (en && edge_det) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end
      // A saturated hold is not an increment, so hit is not re-evaluated.
      if (!at_max || (SATURATE == 0)) begin
        cnt_d = inc_val;
        if (inc_val == thresh) begin
          hit_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign hit = hit_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/edge_counter_bank.sv
// rtl/edge_counter_bank.sv - bank of NCHAN edge event counters with registered readout mux
//
// Purpose: NCHAN independent edge counters sharing enable and threshold, plus a
// registered mux presenting the count of the selected channel.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   EVT        : per-channel raw event levels
//   EN         : global count enable
//   CLR        : per-channel synchronous clear
//   THRESH     : shared threshold
//   SEL        : readout channel select
//   XOUT       : registered count of channel SEL (0 when SEL >= NCHAN)
//   HIT, OVF   : per-channel sticky threshold / overflow flags
module edge_counter_bank
  import edge_counter_pkg::*;
#(
  parameter int NCHAN     = 4,
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = 0,
  parameter int SATURATE  = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NCHAN-1:0]            EVT,
  input  logic                        EN,
  input  logic [NCHAN-1:0]            CLR,
  input  logic [WIDTH-1:0]            THRESH,
  input  logic [sel_width(NCHAN)-1:0] SEL,
  output logic [WIDTH-1:0]            XOUT,
  output logic [NCHAN-1:0]            HIT,
  output logic [NCHAN-1:0]            OVF
);

  logic [WIDTH-1:0] cnt [NCHAN];
  logic [WIDTH-1:0] xout_q, xout_d;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    edge_counter_chan #(
      .WIDTH     (WIDTH),
      .EDGE_MODE (EDGE_MODE),
      .SATURATE  (SATURATE)
    ) u_chan (
      .clk    (CLK),
      .reset  (RESET),
      .evt    (EVT[i]),
      .en     (EN),
      .clr    (CLR[i]),
      .thresh (THRESH),
      .cnt    (cnt[i]),
      .hit    (HIT[i]),
      .ovf    (OVF[i])
    );
  end

  // Loop compare keeps out-of-range selects (non power-of-two NCHAN) reading 0.
  always_comb begin
    xout_d = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (int'(SEL) == i) begin
        xout_d = cnt[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      xout_q <= '0;
    end else begin
      xout_q <= xout_d;
    end
  end

  assign XOUT = xout_q;

endmodule

// File: tb/tb_edge_counter_bank.sv
// tb/tb_edge_counter_bank.sv - directed self-checking bench for edge_counter_bank
module tb_edge_counter_bank;

  logic       clk;
  logic       reset;
  logic [3:0] evt;
  logic       en;
  logic [3:0] clr;
  logic [3:0] thresh;
  logic [2:0] sel;

  logic [3:0] xout_sat, xout_wrap, xout_both;
  logic [3:0] hit_sat, hit_wrap, ovf_sat, ovf_wrap;
  logic [4:0] hit_both, ovf_both;

  int n_vec;
  int n_miss;

  // Rising edge, 4-bit, saturating.
  edge_counter_bank #(.NCHAN(4), .WIDTH(4), .EDGE_MODE(0), .SATURATE(1)) u_sat (
    .CLK(clk), .RESET(reset), .EVT(evt), .EN(en), .CLR(clr), .THRESH(thresh),
    .SEL(sel[1:0]), .XOUT(xout_sat), .HIT(hit_sat), .OVF(ovf_sat)
  );

  // Rising edge, 4-bit, wrapping.
  edge_counter_bank #(.NCHAN(4), .WIDTH(4), .EDGE_MODE(0), .SATURATE(0)) u_wrap (
    .CLK(clk), .RESET(reset), .EVT(evt), .EN(en), .CLR(clr), .THRESH(thresh),
    .SEL(sel[1:0]), .XOUT(xout_wrap), .HIT(hit_wrap), .OVF(ovf_wrap)
  );

  // Both edges, 5 channels so a 3-bit select can address past NCHAN.
  edge_counter_bank #(.NCHAN(5), .WIDTH(4), .EDGE_MODE(2), .SATURATE(1)) u_both (
    .CLK(clk), .RESET(reset), .EVT({1'b0, evt}), .EN(en), .CLR({1'b0, clr}), .THRESH(thresh),
    .SEL(sel), .XOUT(xout_both), .HIT(hit_both), .OVF(ovf_both)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch);
    evt[ch] = 1'b1;
    tick();
    evt[ch] = 1'b0;
    tick();
  endtask

  task automatic pulses(input int ch, input int n);
    for (int k = 0; k < n; k++) pulse(ch);
  endtask

  task automatic point(input logic [2:0] s);
    sel = s;
    tick();
  endtask

  task automatic clear_all();
    clr = 4'hF;
    tick();
    clr = 4'h0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    evt    = 4'hF;
    en     = 1'b1;
    clr    = 4'h0;
    thresh = 4'hA;
    sel    = 3'd0;

    // Reset with all events high.
    tick();
    tick();
    expect_eq("rst_xout", {28'd0, xout_sat}, 32'd0);
    expect_eq("rst_hit", {28'd0, hit_sat}, 32'd0);
    expect_eq("rst_ovf", {28'd0, ovf_sat}, 32'd0);

    // Release with EVT[0] still high: exactly one edge, seen on XOUT 2 clocks later.
    reset = 1'b0;
    evt   = 4'b0001;
    tick();
    expect_eq("rel_lat1", {28'd0, xout_sat}, 32'd0);
    tick();
    expect_eq("rel_lat2", {28'd0, xout_sat}, 32'd1);
    tick();
    tick();
    expect_eq("rel_hold", {28'd0, xout_sat}, 32'd1);
    evt = 4'b0000;
    tick();

    // Five pulses on channel 1.
    clear_all();
    sel = 3'd1;
    for (int n = 1; n <= 5; n++) begin
      evt[1] = 1'b1;
      tick();
      expect_eq($sformatf("cnt_pre%0d", n), {28'd0, xout_sat}, n - 1);
      evt[1] = 1'b0;
      tick();
      expect_eq($sformatf("cnt_post%0d", n), {28'd0, xout_sat}, n);
    end
    point(3'd0);
    expect_eq("idle_ch0", {28'd0, xout_sat}, 32'd0);
    point(3'd2);
    expect_eq("idle_ch2", {28'd0, xout_sat}, 32'd0);
    point(3'd3);
    expect_eq("idle_ch3", {28'd0, xout_sat}, 32'd0);

    // Overflow on channel 0.
    clear_all();
    sel = 3'd0;
    pulses(0, 15);
    expect_eq("ovf15_sat", {28'd0, xout_sat}, 32'd15);
    expect_eq("ovf15_wrap", {28'd0, xout_wrap}, 32'd15);
    expect_eq("ovf15_flag", {31'd0, ovf_sat[0]}, 32'd0);
    evt[0] = 1'b1;
    tick();
    expect_eq("ovf16_sat_flag", {31'd0, ovf_sat[0]}, 32'd1);
    expect_eq("ovf16_wrap_flag", {31'd0, ovf_wrap[0]}, 32'd1);
    evt[0] = 1'b0;
    tick();
    expect_eq("ovf16_sat", {28'd0, xout_sat}, 32'd15);
    expect_eq("ovf16_wrap", {28'd0, xout_wrap}, 32'd0);
    pulse(0);
    expect_eq("ovf17_sat", {28'd0, xout_sat}, 32'd15);
    expect_eq("ovf17_wrap", {28'd0, xout_wrap}, 32'd1);

    // Threshold on channel 0.
    clear_all();
    thresh = 4'd3;
    pulses(0, 2);
    expect_eq("hit_pre", {31'd0, hit_sat[0]}, 32'd0);
    evt[0] = 1'b1;
    tick();
    expect_eq("hit_at3", {31'd0, hit_sat[0]}, 32'd1);
    evt[0] = 1'b0;
    tick();
    thresh = 4'd9;
    tick();
    expect_eq("hit_sticky", {31'd0, hit_sat[0]}, 32'd1);
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    expect_eq("clr_hit", {31'd0, hit_sat[0]}, 32'd0);
    expect_eq("clr_ovf", {31'd0, ovf_sat[0]}, 32'd0);
    point(3'd0);
    expect_eq("clr_cnt", {28'd0, xout_sat}, 32'd0);

    // THRESH=0 is hit only by a wrap to 0.
    clear_all();
    thresh = 4'd0;
    pulses(0, 15);
    expect_eq("hit0_pre_wrap", {31'd0, hit_wrap[0]}, 32'd0);
    pulse(0);
    expect_eq("hit0_wrap", {31'd0, hit_wrap[0]}, 32'd1);
    expect_eq("hit0_sat", {31'd0, hit_sat[0]}, 32'd0);

    // EN gating.
    clear_all();
    thresh = 4'hA;
    pulse(0);
    en = 1'b0;
    pulses(0, 4);
    en = 1'b1;
    point(3'd0);
    expect_eq("en_gate", {28'd0, xout_sat}, 32'd1);
    en     = 1'b0;
    evt[0] = 1'b1;
    tick();
    tick();
    en = 1'b1;
    tick();
    tick();
    evt[0] = 1'b0;
    tick();
    tick();
    expect_eq("en_rise_high", {28'd0, xout_sat}, 32'd1);

    // CLR beats a same-cycle edge.
    pulse(2);
    clr[2] = 1'b1;
    evt[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    tick();
    evt[2] = 1'b0;
    tick();
    point(3'd2);
    expect_eq("clr_prio", {28'd0, xout_sat}, 32'd0);
    point(3'd0);
    expect_eq("clr_indep", {28'd0, xout_sat}, 32'd1);

    // Both-edge mode: 3 full periods on EVT[3].
    clear_all();
    for (int p = 0; p < 3; p++) begin
      evt[3] = 1'b1;
      tick();
      tick();
      evt[3] = 1'b0;
      tick();
      tick();
    end
    point(3'd3);
    expect_eq("both_cnt", {28'd0, xout_both}, 32'd6);
    expect_eq("rise_cnt", {28'd0, xout_sat}, 32'd3);
    expect_eq("both_ovf", {27'd0, ovf_both}, 32'd0);
    point(3'd7);
    expect_eq("sel_oob", {28'd0, xout_both}, 32'd0);
    point(3'd3);
    point(3'd5);
    expect_eq("sel_oob5", {28'd0, xout_both}, 32'd0);
    expect_eq("both_hit", {27'd0, hit_both}, 32'd0);

    // Reset mid-count loses the count.
    point(3'd3);
    reset = 1'b1;
    tick();
    expect_eq("rst_mid_xout", {28'd0, xout_sat}, 32'd0);
    reset = 1'b0;
    point(3'd3);
    expect_eq("rst_mid_cnt", {28'd0, xout_sat}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
